sat_cmd_sequencer: RTL and testbench

- Parametrised, buffered successor to the SAT control decoder.
- Accepts packed SAT commands over a valid/ready interface and queues them in a small FIFO.
- Issues one command per cycle as registered clause/CNF control strobes to the SAT datapath.
- Adds a result-capture opcode, a clause counter and illegal-opcode detection.

---
 rtl/sat_pkg.sv | 24 ++
 rtl/sat_cmd_sequencer_if.sv | 16 +
 rtl/sat_cmd_fifo.sv | 66 ++++++
 rtl/sat_cmd_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_sat_cmd_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sat_pkg.sv
// Shared definitions for the SAT command sequencer: opcodes, FSM states and
// the command-word width helper.
package sat_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_RESET_SAT      = 3'd0;
  localparam logic [OP_W-1:0] OP_COMPUTE_CLAUSE = 3'd1;
  localparam logic [OP_W-1:0] OP_COMPUTE_CNF    = 3'd2;
  localparam logic [OP_W-1:0] OP_RESET_CLAUSE   = 3'd3;
  localparam logic [OP_W-1:0] OP_END_CNF        = 3'd4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2
  } sat_state_e;

  // Command word is {op, varPos, neg}.
  function automatic int unsigned cmd_width(input int unsigned var_w);
    return OP_W + var_w + 1;
  endfunction

endpackage

// File: rtl/sat_cmd_sequencer_if.sv
// Command channel into the sequencer: packed command plus valid/ready.
//   master : producer (drives cmd_in, cmd_valid; sees cmd_ready)
//   slave  : sequencer (sees cmd_in, cmd_valid; drives cmd_ready)
interface sat_cmd_sequencer_if #(
  parameter int unsigned VAR_W = 5
);
  localparam int unsigned CMD_W = sat_pkg::cmd_width(VAR_W);

  logic [CMD_W-1:0] cmd_in;
  logic             cmd_valid;
  logic             cmd_ready;

  modport master (output cmd_in, output cmd_valid, input cmd_ready);
  modport slave  (input cmd_in, input cmd_valid, output cmd_ready);

endinterface

// File: rtl/sat_cmd_fifo.sv
// Small synchronous FIFO for queued SAT commands.
//   clk, resetN      : clock, async active-low reset (empties the FIFO)
//   push, wr_data    : write request (ignored when full)
//   pop, rd_data     : read request (ignored when empty); rd_data shows the head
//   full, empty      : occupancy flags, combinational from the count register
module sat_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == OCC_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^n.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes stale entries.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sat_cmd_sequencer.sv
// Buffered SAT command sequencer: queues packed commands and issues one per
// cycle as registered clause/CNF control strobes, captures the CNF result
// after END_CNF, counts closed clauses and flags illegal opcodes.
//   clk, resetN      : clock, async active-low reset
//   cmd_bus          : command channel (cmd_in/cmd_valid in, cmd_ready out)
//   ResetN_Clause/CNF: active-low accumulator clears
//   Clause_En/CNF_En : accumulate enables
//   varPos, negCtrl  : literal select and negation
//   cnf_in           : current CNF accumulator value
//   sat_result       : captured CNF value, result_valid pulses when updated
//   clause_count     : clauses closed since last RESET_SAT (saturating)
//   cmd_error        : sticky illegal-opcode flag
//   busy             : queue non-empty or FSM not idle
module sat_cmd_sequencer
  import sat_pkg::*;
#(
  parameter int unsigned VAR_W = 5,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetN,
  sat_cmd_sequencer_if.slave cmd_bus,
  output logic             ResetN_Clause,
  output logic             ResetN_CNF,
  output logic             Clause_En,
  output logic             CNF_En,
  output logic [VAR_W-1:0] varPos,
  output logic             negCtrl,
  input  logic             cnf_in,
  output logic             sat_result,
  output logic             result_valid,
  output logic [CNT_W-1:0] clause_count,
  output logic             cmd_error,
  output logic             busy
);

  localparam int unsigned CMD_W = cmd_width(VAR_W);

  logic [CMD_W-1:0] head_cmd;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic [OP_W-1:0]  head_op;
  logic [VAR_W-1:0] head_var;
  logic             head_neg;

  sat_state_e state_q, state_d;

  logic             rst_clause_q, rst_clause_d;
  logic             rst_cnf_q, rst_cnf_d;
  logic             clause_en_q, clause_en_d;
  logic             cnf_en_q, cnf_en_d;
  logic [VAR_W-1:0] var_pos_q, var_pos_d;
  logic             neg_ctrl_q, neg_ctrl_d;
  logic             sat_result_q, sat_result_d;
  logic             result_valid_q, result_valid_d;
  logic [CNT_W-1:0] clause_count_q, clause_count_d;
  logic             cmd_error_q, cmd_error_d;

  // No bypass: ready follows the registered occupancy only.
  assign cmd_bus.cmd_ready = !fifo_full;
  assign push              = cmd_bus.cmd_valid && !fifo_full;
  // WAIT_RES is the only state that holds the queue.
  assign pop               = (state_q != WAIT_RES) && !fifo_empty;

  sat_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .resetN  (resetN),
    .push    (push),
    .wr_data (cmd_bus.cmd_in),
    .pop     (pop),
    .rd_data (head_cmd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_op  = head_cmd[CMD_W-1 -: OP_W];
  assign head_var = head_cmd[VAR_W:1];
  assign head_neg = head_cmd[0];

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ISSUE: begin
        if (pop) state_d = (head_op == OP_END_CNF) ? WAIT_RES : ISSUE;
        else     state_d = IDLE;
      end
      WAIT_RES: state_d = fifo_empty ? IDLE : ISSUE;
      default:  state_d = IDLE;
    endcase
  end

  // Output logic: enables default low, everything else holds unless decoded.
  always_comb begin
    rst_clause_d   = rst_clause_q;
    rst_cnf_d      = rst_cnf_q;
    clause_en_d    = 1'b0;
    cnf_en_d       = 1'b0;
    var_pos_d      = var_pos_q;
    neg_ctrl_d     = neg_ctrl_q;
    sat_result_d   = sat_result_q;
    result_valid_d = 1'b0;
    clause_count_d = clause_count_q;
    cmd_error_d    = cmd_error_q;

    if (state_q == WAIT_RES) begin
      sat_result_d   = cnf_in;
      result_valid_d = 1'b1;
    end

    if (pop) begin
      case (head_op)
        OP_RESET_SAT: begin
          rst_clause_d   = 1'b0;
          rst_cnf_d      = 1'b0;
          var_pos_d      = head_var;
          neg_ctrl_d     = head_neg;
          clause_count_d = '0;
          cmd_error_d    = 1'b0;
        end
        OP_COMPUTE_CLAUSE: begin
          rst_clause_d = 1'b1;
          rst_cnf_d    = 1'b1;
          clause_en_d  = 1'b1;
          var_pos_d    = head_var;
          neg_ctrl_d   = head_neg;
        end
        OP_COMPUTE_CNF: begin
          rst_clause_d = 1'b1;
          rst_cnf_d    = 1'b1;
          cnf_en_d     = 1'b1;
          var_pos_d    = head_var;
          neg_ctrl_d   = head_neg;
        end
        OP_RESET_CLAUSE: begin
          rst_clause_d = 1'b0;
          rst_cnf_d    = 1'b1;
          var_pos_d    = head_var;
          neg_ctrl_d   = head_neg;
          if (clause_count_q != '1) clause_count_d = clause_count_q + CNT_W'(1);
        end
        OP_END_CNF: begin
          rst_clause_d = 1'b1;
          rst_cnf_d    = 1'b1;
          var_pos_d    = head_var;
          neg_ctrl_d   = head_neg;
        end
        default: cmd_error_d = 1'b1;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rst_clause_q   <= 1'b0;
      rst_cnf_q      <= 1'b0;
      clause_en_q    <= 1'b0;
      cnf_en_q       <= 1'b0;
      var_pos_q      <= '0;
      neg_ctrl_q     <= 1'b0;
      sat_result_q   <= 1'b0;
      result_valid_q <= 1'b0;
      clause_count_q <= '0;
      cmd_error_q    <= 1'b0;
    end else begin
      rst_clause_q   <= rst_clause_d;
      rst_cnf_q      <= rst_cnf_d;
      clause_en_q    <= clause_en_d;
      cnf_en_q       <= cnf_en_d;
      var_pos_q      <= var_pos_d;
      neg_ctrl_q     <= neg_ctrl_d;
      sat_result_q   <= sat_result_d;
      result_valid_q <= result_valid_d;
      clause_count_q <= clause_count_d;
      cmd_error_q    <= cmd_error_d;
    end
  end

  assign ResetN_Clause = rst_clause_q;
  assign ResetN_CNF    = rst_cnf_q;
  assign Clause_En     = clause_en_q;
  assign CNF_En        = cnf_en_q;
  assign varPos        = var_pos_q;
  assign negCtrl       = neg_ctrl_q;
  assign sat_result    = sat_result_q;
  assign result_valid  = result_valid_q;
  assign clause_count  = clause_count_q;
  assign cmd_error     = cmd_error_q;
  assign busy          = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_sat_cmd_sequencer.sv
module tb_sat_cmd_sequencer;
  import sat_pkg::*;

  logic clk;
  logic rst_n;

  sat_cmd_sequencer_if #(.VAR_W(5)) bus0 ();
  sat_cmd_sequencer_if #(.VAR_W(5)) bus1 ();

  // Main DUT (CNT_W = 8)
  logic       a_rc, a_rcnf, a_cen, a_nen, a_neg, a_cnf, a_res, a_rv, a_err, a_busy;
  logic [4:0] a_var;
  logic [7:0] a_cnt;
  // Saturation DUT (CNT_W = 2)
  logic       b_rc, b_rcnf, b_cen, b_nen, b_neg, b_res, b_rv, b_err, b_busy;
  logic [4:0] b_var;
  logic [1:0] b_cnt;

  sat_cmd_sequencer #(.VAR_W(5), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .resetN(rst_n), .cmd_bus(bus0),
    .ResetN_Clause(a_rc), .ResetN_CNF(a_rcnf), .Clause_En(a_cen), .CNF_En(a_nen),
    .varPos(a_var), .negCtrl(a_neg), .cnf_in(a_cnf), .sat_result(a_res),
    .result_valid(a_rv), .clause_count(a_cnt), .cmd_error(a_err), .busy(a_busy)
  );

  sat_cmd_sequencer #(.VAR_W(5), .DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .resetN(rst_n), .cmd_bus(bus1),
    .ResetN_Clause(b_rc), .ResetN_CNF(b_rcnf), .Clause_En(b_cen), .CNF_En(b_nen),
    .varPos(b_var), .negCtrl(b_neg), .cnf_in(1'b0), .sat_result(b_res),
    .result_valid(b_rv), .clause_count(b_cnt), .cmd_error(b_err), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int stall_cnt = 0;

  // Issue monitor for the back-pressure test
  logic       mon_en = 1'b0;
  int         rv_cnt;
  logic [4:0] last_vp;
  logic [4:0] vp_log [$];

  always @(negedge clk) begin
    if (!mon_en) begin
      rv_cnt = 0;
      vp_log.delete();
      last_vp = a_var;
    end else begin
      if (a_rv) rv_cnt++;
      if (a_var != last_vp) begin
        vp_log.push_back(a_var);
        last_vp = a_var;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command and hold it until accepted; returns just after the accepting edge.
  task automatic push(input bit which, input logic [2:0] op, input logic [4:0] vp, input logic ng);
    int guard = 0;
    if (!which) begin
      bus0.cmd_in = {op, vp, ng};
      bus0.cmd_valid = 1'b1;
      while (!bus0.cmd_ready && guard < 50) begin stall_cnt++; guard++; step(); end
    end else begin
      bus1.cmd_in = {op, vp, ng};
      bus1.cmd_valid = 1'b1;
      while (!bus1.cmd_ready && guard < 50) begin stall_cnt++; guard++; step(); end
    end
    if (guard >= 50) chk("push_timeout", 32'(guard), 0);
    step();
  endtask

  task automatic release_bus();
    bus0.cmd_valid = 1'b0;
    bus1.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit which, input string tag);
    int guard = 0;
    while ((which ? b_busy : a_busy) && guard < 100) begin guard++; step(); end
    chk(tag, 32'(which ? b_busy : a_busy), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rc"},    32'(a_rc), 0);
    chk({tag, "_rcnf"},  32'(a_rcnf), 0);
    chk({tag, "_cen"},   32'(a_cen), 0);
    chk({tag, "_nen"},   32'(a_nen), 0);
    chk({tag, "_var"},   32'(a_var), 0);
    chk({tag, "_neg"},   32'(a_neg), 0);
    chk({tag, "_res"},   32'(a_res), 0);
    chk({tag, "_rv"},    32'(a_rv), 0);
    chk({tag, "_cnt"},   32'(a_cnt), 0);
    chk({tag, "_err"},   32'(a_err), 0);
    chk({tag, "_busy"},  32'(a_busy), 0);
    chk({tag, "_ready"}, 32'(bus0.cmd_ready), 1);
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    a_cnf = 1'b0;
    bus0.cmd_in = '0; bus0.cmd_valid = 1'b0;
    bus1.cmd_in = '0; bus1.cmd_valid = 1'b0;

    // Reset state
    repeat (3) step();
    chk_reset_outputs("rst");
    #2 rst_n = 1'b1;
    step();

    // Single COMPUTE_CLAUSE: outputs one edge after acceptance, then enables drop
    push(0, OP_COMPUTE_CLAUSE, 5'd3, 1'b0);
    release_bus();
    chk("t1_cen_before", 32'(a_cen), 0);
    step();
    chk("t1_cen", 32'(a_cen), 1);
    chk("t1_rc", 32'(a_rc), 1);
    chk("t1_rcnf", 32'(a_rcnf), 1);
    chk("t1_var", 32'(a_var), 3);
    chk("t1_neg", 32'(a_neg), 0);
    step();
    chk("t1_cen_idle", 32'(a_cen), 0);
    chk("t1_var_hold", 32'(a_var), 3);
    chk("t1_rc_hold", 32'(a_rc), 1);
    chk("t1_busy", 32'(a_busy), 0);

    // Back-pressure: ten END_CNF back-to-back, each holds the queue a cycle
    stall_cnt = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) push(0, OP_END_CNF, 5'(11 + i), 1'b0);
    release_bus();
    wait_idle(0, "t2_idle");
    step(); step();
    mon_en = 1'b0;
    chk("t2_stalls", 32'(stall_cnt), 3);
    chk("t2_results", 32'(rv_cnt), 10);
    chk("t2_issued", 32'(vp_log.size()), 10);
    for (int i = 0; i < 10 && i < vp_log.size(); i++)
      chk("t2_order", 32'(vp_log[i]), 32'(11 + i));

    // COMPUTE_CNF, END_CNF with cnf_in=1, then a clause held through WAIT_RES
    a_cnf = 1'b1;
    push(0, OP_COMPUTE_CNF, 5'd7, 1'b1);
    push(0, OP_END_CNF, 5'd4, 1'b0);
    chk("t3_nen", 32'(a_nen), 1);
    chk("t3_cen", 32'(a_cen), 0);
    chk("t3_var", 32'(a_var), 7);
    chk("t3_neg", 32'(a_neg), 1);
    push(0, OP_COMPUTE_CLAUSE, 5'd9, 1'b0);
    release_bus();
    chk("t3_end_nen", 32'(a_nen), 0);
    chk("t3_end_rv", 32'(a_rv), 0);
    chk("t3_end_var", 32'(a_var), 4);
    step();
    chk("t3_rv", 32'(a_rv), 1);
    chk("t3_res", 32'(a_res), 1);
    chk("t3_wait_nopop", 32'(a_cen), 0);
    chk("t3_wait_var", 32'(a_var), 4);
    step();
    chk("t3_rv_drop", 32'(a_rv), 0);
    chk("t3_cl_cen", 32'(a_cen), 1);
    chk("t3_cl_var", 32'(a_var), 9);
    a_cnf = 1'b0;
    wait_idle(0, "t3_idle");

    // Clause counter
    for (int i = 0; i < 3; i++) push(0, OP_RESET_CLAUSE, 5'd1, 1'b0);
    release_bus();
    wait_idle(0, "t4_idle");
    chk("t4_cnt3", 32'(a_cnt), 3);
    chk("t4_rc", 32'(a_rc), 0);
    chk("t4_rcnf", 32'(a_rcnf), 1);
    push(0, OP_RESET_SAT, 5'd0, 1'b0);
    release_bus();
    wait_idle(0, "t4_idle2");
    chk("t4_cnt0", 32'(a_cnt), 0);
    chk("t4_rcnf0", 32'(a_rcnf), 0);
    for (int i = 0; i < 2; i++) push(1, OP_RESET_CLAUSE, 5'd2, 1'b0);
    release_bus();
    wait_idle(1, "t4_b_idle");
    chk("t4_b_cnt2", 32'(b_cnt), 2);
    for (int i = 0; i < 3; i++) push(1, OP_RESET_CLAUSE, 5'd2, 1'b0);
    release_bus();
    wait_idle(1, "t4_b_idle2");
    chk("t4_b_sat", 32'(b_cnt), 3);

    // Illegal opcode
    push(0, OP_COMPUTE_CLAUSE, 5'd11, 1'b0);
    push(0, 3'd6, 5'd20, 1'b1);
    release_bus();
    chk("t5_pre_cen", 32'(a_cen), 1);
    chk("t5_pre_err", 32'(a_err), 0);
    step();
    chk("t5_err", 32'(a_err), 1);
    chk("t5_cen", 32'(a_cen), 0);
    chk("t5_nen", 32'(a_nen), 0);
    chk("t5_var", 32'(a_var), 11);
    chk("t5_neg", 32'(a_neg), 0);
    chk("t5_rc", 32'(a_rc), 1);
    push(0, OP_COMPUTE_CLAUSE, 5'd12, 1'b1);
    release_bus();
    step();
    chk("t5_next_cen", 32'(a_cen), 1);
    chk("t5_next_var", 32'(a_var), 12);
    chk("t5_next_neg", 32'(a_neg), 1);
    chk("t5_sticky", 32'(a_err), 1);
    push(0, OP_RESET_SAT, 5'd0, 1'b0);
    release_bus();
    step();
    chk("t5_clr_err", 32'(a_err), 0);
    chk("t5_clr_rc", 32'(a_rc), 0);
    wait_idle(0, "t5_idle");

    // Async reset with three commands queued and Clause_En high
    push(0, OP_COMPUTE_CLAUSE, 5'd1, 1'b0);
    for (int i = 0; i < 4; i++) push(0, OP_END_CNF, 5'(2 + i), 1'b0);
    for (int i = 0; i < 4; i++) push(0, OP_COMPUTE_CLAUSE, 5'(6 + i), 1'b0);
    release_bus();
    step();
    chk("t6_pre_cen", 32'(a_cen), 1);
    chk("t6_pre_var", 32'(a_var), 6);
    chk("t6_pre_busy", 32'(a_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    step();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_no_issue", 32'(a_cen), 0);
    end
    chk("t6_var", 32'(a_var), 0);
    chk("t6_busy", 32'(a_busy), 0);
    chk("t6_ready", 32'(bus0.cmd_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
